// File: rtl/spi_master_flash.sv
// spi_master_flash -- SPI mode-0 master for serial NOR flash style transactions.
//
// A request is latched in IDLE when validflag is high. One frame is then shifted
// out MSB-first: the command, then the address and write data if the type needs
// them, then R read bits. During the read bits mosi is held low and miso is
// captured. After the frame, the block spends one DONE cycle and returns to IDLE.
//
// Ports
//   clk           system clock; all logic runs on its rising edge
//   rst           asynchronous, active-low reset
//   ss            flash chip select, active-low
//   sclk          SPI clock; each half-period lasts SCLK_HALF clk cycles
//   mosi / miso   serial data to / from the flash
//   data_in       32-bit write payload (commtype 011)
//   data_out      read result, right-aligned; updated only when a read completes
//   address       flash address; only [23:0] is sent
//   command       8-bit opcode
//   commtype      000 cmd, 001 cmd+read, 010 cmd+addr+read, 011 cmd+addr+write,
//                 100 cmd+addr, 101..111 treated as 000
//   nmiso_bits    number of bits to read (clamped to 32)
//   validflag     request strobe, sampled only in IDLE
//   validflag_out one-cycle pulse in the DONE cycle
//   tready        high while idle and able to accept a request
module spi_master_flash #(
   parameter int SCLK_HALF = 1
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ss,
   output logic        sclk,
   output logic        mosi,
   input  logic        miso,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   input  logic [31:0] address,
   input  logic [7:0]  command,
   input  logic [2:0]  commtype,
   input  logic [6:0]  nmiso_bits,
   input  logic        validflag,
   output logic        validflag_out,
   output logic        tready
);

   localparam int HW = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
   localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
   localparam logic [HW-1:0] HALF_ONE  = HW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic            ss_nxt, sclk_nxt, mosi_nxt, tready_nxt, validflag_out_nxt;
   logic [31:0]     data_out_nxt;
   logic [63:0]     tx, tx_nxt;          // outgoing bits, left-aligned, zero-filled
   logic [31:0]     rx, rx_nxt;          // captured read bits
   logic [6:0]      bit_cnt, bit_cnt_nxt;
   logic [6:0]      nbits, nbits_nxt;    // total frame length
   logic [6:0]      txlen, txlen_nxt;    // bits before the read phase
   logic            rd, rd_nxt;          // frame has a non-empty read phase
   logic [HW-1:0]   half_cnt, half_cnt_nxt;

   logic [63:0]     req_frame;
   logic [6:0]      req_txlen;
   logic [6:0]      req_rbits;
   logic            req_read;

   // Decode the incoming request into a left-aligned frame and its field lengths.
   always_comb begin
      req_frame = {command, 56'd0};
      req_txlen = 7'd8;
      req_read  = 1'b0;
      case (commtype)
         3'b001: begin
            req_read = 1'b1;
         end
         3'b010: begin
            req_frame = {command, address[23:0], 32'd0};
            req_txlen = 7'd32;
            req_read  = 1'b1;
         end
         3'b011: begin
            req_frame = {command, address[23:0], data_in};
            req_txlen = 7'd64;
         end
         3'b100: begin
            req_frame = {command, address[23:0], 32'd0};
            req_txlen = 7'd32;
         end
         default: begin
            req_frame = {command, 56'd0};
            req_txlen = 7'd8;
            req_read  = 1'b0;
         end
      endcase
      if (!req_read) begin
         req_rbits = 7'd0;
      end else if (nmiso_bits > 7'd32) begin
         req_rbits = 7'd32;
      end else begin
         req_rbits = nmiso_bits;
      end
   end

   // Next-state and next-output logic for the IDLE/SHIFT/DONE sequencer.
   always_comb begin
      state_nxt         = state;
      ss_nxt            = ss;
      sclk_nxt          = sclk;
      mosi_nxt          = mosi;
      tready_nxt        = tready;
      validflag_out_nxt = 1'b0;
      data_out_nxt      = data_out;
      tx_nxt            = tx;
      rx_nxt            = rx;
      bit_cnt_nxt       = bit_cnt;
      half_cnt_nxt      = half_cnt;
      nbits_nxt         = nbits;
      txlen_nxt         = txlen;
      rd_nxt            = rd;
      case (state)
         IDLE: begin
            ss_nxt     = 1'b1;
            sclk_nxt   = 1'b0;
            mosi_nxt   = 1'b0;
            tready_nxt = 1'b1;
            if (validflag) begin
               state_nxt    = SHIFT;
               ss_nxt       = 1'b0;
               tready_nxt   = 1'b0;
               mosi_nxt     = req_frame[63];   // first bit valid as ss falls
               tx_nxt       = req_frame;
               rx_nxt       = 32'd0;
               bit_cnt_nxt  = 7'd0;
               half_cnt_nxt = '0;
               txlen_nxt    = req_txlen;
               nbits_nxt    = req_txlen + req_rbits;
               rd_nxt       = (req_rbits != 7'd0);
            end else begin
               state_nxt = IDLE;
            end
         end
         SHIFT: begin
            if (half_cnt == HALF_LAST) begin
               half_cnt_nxt = '0;
               if (!sclk) begin
                  // Rising sclk: capture miso, but only during the read phase so
                  // that data_out above the read width stays zero.
                  sclk_nxt = 1'b1;
                  if (bit_cnt >= txlen) begin
                     rx_nxt = {rx[30:0], miso};
                  end else begin
                     rx_nxt = rx;
                  end
               end else begin
                  // Falling sclk: either the frame ends or the next bit goes out.
                  sclk_nxt = 1'b0;
                  if (bit_cnt == nbits - 7'd1) begin
                     state_nxt         = DONE;
                     ss_nxt            = 1'b1;
                     mosi_nxt          = 1'b0;
                     validflag_out_nxt = 1'b1;
                     if (rd) begin
                        data_out_nxt = rx;
                     end else begin
                        data_out_nxt = data_out;
                     end
                  end else begin
                     bit_cnt_nxt = bit_cnt + 7'd1;
                     tx_nxt      = {tx[62:0], 1'b0};
                     mosi_nxt    = tx[62];           // zeros once past the tx fields
                  end
               end
            end else begin
               half_cnt_nxt = half_cnt + HALF_ONE;
            end
         end
         DONE: begin
            state_nxt  = IDLE;
            tready_nxt = 1'b1;
         end
         default: begin
            state_nxt  = IDLE;
            ss_nxt     = 1'b1;
            sclk_nxt   = 1'b0;
            mosi_nxt   = 1'b0;
            tready_nxt = 1'b1;
         end
      endcase
   end

   // State and output registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         ss            <= 1'b1;
         sclk          <= 1'b0;
         mosi          <= 1'b0;
         tready        <= 1'b1;
         validflag_out <= 1'b0;
         data_out      <= 32'd0;
         tx            <= 64'd0;
         rx            <= 32'd0;
         bit_cnt       <= 7'd0;
         half_cnt      <= '0;
         nbits         <= 7'd0;
         txlen         <= 7'd0;
         rd            <= 1'b0;
      end else begin
         state         <= state_nxt;
         ss            <= ss_nxt;
         sclk          <= sclk_nxt;
         mosi          <= mosi_nxt;
         tready        <= tready_nxt;
         validflag_out <= validflag_out_nxt;
         data_out      <= data_out_nxt;
         tx            <= tx_nxt;
         rx            <= rx_nxt;
         bit_cnt       <= bit_cnt_nxt;
         half_cnt      <= half_cnt_nxt;
         nbits         <= nbits_nxt;
         txlen         <= txlen_nxt;
         rd            <= rd_nxt;
      end
   end

endmodule

// File: tb/tb_spi_master_flash.sv
// tb_spi_master_flash -- scoreboard bench for spi_master_flash.
// Each request pushes its expected mosi frame, length and data_out into a queue;
// a monitor rebuilds the frame from the pins and compares when ss rises.
module tb_spi_master_flash;
   localparam int H = 1;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        ss, sclk, mosi, validflag_out, tready;
   logic        miso = 1'b0;
   logic [31:0] data_in = 32'd0, address = 32'd0, data_out;
   logic [7:0]  command = 8'd0;
   logic [2:0]  commtype = 3'd0;
   logic [6:0]  nmiso_bits = 7'd0;
   logic        validflag = 1'b0;

   spi_master_flash #(.SCLK_HALF(H)) dut (
      .clk(clk), .rst(rst), .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso),
      .data_in(data_in), .data_out(data_out), .address(address),
      .command(command), .commtype(commtype), .nmiso_bits(nmiso_bits),
      .validflag(validflag), .validflag_out(validflag_out), .tready(tready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] frame;   // right-aligned expected mosi bits
      int          nbits;
      logic [31:0] dout;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_pass = 0;
   int          vf_cnt = 0;
   logic [31:0] model_dout = 32'd0;
   logic [63:0] miso_pat = 64'd0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_checks++;
      if (obs === expv) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, expv);
   endtask

   // Flash model: bit k of the frame is miso_pat[63-k], changed on sclk falling.
   int miso_idx = 0;
   always @(negedge ss) begin
      miso_idx = 0;
      miso = miso_pat[63];
   end
   always @(negedge sclk) begin
      if (!ss) begin
         miso_idx++;
         miso = (miso_idx < 64) ? miso_pat[63 - miso_idx] : 1'b0;
      end
   end

   // Monitor.
   logic        ss_prev = 1'b1;
   bit          in_frame = 1'b0;
   bit          done_pend = 1'b0;
   int          low_cnt = 0;
   int          nseen = 0;
   logic [63:0] mframe = 64'd0;
   exp_t        cur;

   always @(posedge sclk) begin
      if (!ss) begin
         mframe = {mframe[62:0], mosi};
         nseen++;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         ss_prev   = 1'b1;
         in_frame  = 1'b0;
         done_pend = 1'b0;
      end else begin
         if (validflag_out) vf_cnt++;
         if (done_pend) begin
            check("tready_back", 64'(tready), 64'd1);
            check("vf_one_cycle", 64'(validflag_out), 64'd0);
            done_pend = 1'b0;
         end
         if (ss_prev && !ss) begin
            low_cnt = 0; nseen = 0; mframe = 64'd0; in_frame = 1'b1;
            if (exp_q.size() > 0) begin
               cur = exp_q[0];
               check("first_bit", 64'(mosi), 64'(cur.frame[cur.nbits-1]));
            end else begin
               check("unexpected_frame", 64'd1, 64'd0);
            end
         end
         if (!ss) low_cnt++;
         if (!ss_prev && ss && in_frame) begin
            in_frame = 1'b0;
            if (exp_q.size() == 0) begin
               check("no_expect", 64'd1, 64'd0);
            end else begin
               cur = exp_q.pop_front();
               check("mosi_frame", mframe, cur.frame);
               check("bits", 64'(nseen), 64'(cur.nbits));
               check("ss_low", 64'(low_cnt), 64'(2 * cur.nbits * H));
               check("vf_done", 64'(validflag_out), 64'd1);
               check("tready_done", 64'(tready), 64'd0);
               check("sclk_end", 64'(sclk), 64'd0);
               check("data_out", 64'(data_out), 64'(cur.dout));
               done_pend = 1'b1;
            end
         end
         ss_prev = ss;
      end
   end

   // Drive one request and push its expected result.
   task automatic send(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] din,
                       input logic [2:0] ct, input logic [6:0] nm);
      exp_t        e;
      int          txl, r, t;
      bit          isrd;
      logic [63:0] f, sh;
      t = 0;
      @(negedge clk);
      while (!tready && t < 1000) begin
         @(negedge clk);
         t++;
      end
      check("ready_wait", 64'(tready), 64'd1);
      isrd = 1'b0;
      case (ct)
         3'b001: begin txl = 8;  isrd = 1'b1; f = {56'd0, cmd}; end
         3'b010: begin txl = 32; isrd = 1'b1; f = {32'd0, cmd, addr[23:0]}; end
         3'b011: begin txl = 64; f = {cmd, addr[23:0], din}; end
         3'b100: begin txl = 32; f = {32'd0, cmd, addr[23:0]}; end
         default: begin txl = 8; f = {56'd0, cmd}; end
      endcase
      r = isrd ? ((nm > 7'd32) ? 32 : int'(nm)) : 0;
      f = f << r;
      if (r > 0) begin
         sh = miso_pat << txl;
         sh = sh >> (64 - r);
         model_dout = sh[31:0];
      end
      e.frame = f;
      e.nbits = txl + r;
      e.dout  = model_dout;
      exp_q.push_back(e);
      command = cmd; address = addr; data_in = din; commtype = ct; nmiso_bits = nm;
      validflag = 1'b1;
      @(negedge clk);
      validflag = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || !tready || done_pend) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check("done_timeout", 64'(t < 2000), 64'd1);
      @(negedge clk);
   endtask

   int   vf0;
   exp_t dropped;

   initial begin
      #12;
      check("rst_ss", 64'(ss), 64'd1);
      check("rst_sclk", 64'(sclk), 64'd0);
      check("rst_mosi", 64'(mosi), 64'd0);
      check("rst_tready", 64'(tready), 64'd1);
      check("rst_vf", 64'(validflag_out), 64'd0);
      check("rst_dout", 64'(data_out), 64'd0);
      @(negedge clk);
      rst = 1'b1;

      // Command + 16-bit read; ones in the command phase must not leak.
      miso_pat = {8'hFF, 16'hA0A3, 40'hFF_FFFF_FFFF};
      vf0 = vf_cnt;
      send(8'h05, 32'd0, 32'd0, 3'b001, 7'd16);
      wait_idle();
      check("vf_count_read", 64'(vf_cnt), 64'(vf0 + 1));

      // 64-bit write; data_out holds.
      send(8'h02, 32'h0055_5555, 32'h0000_005A, 3'b011, 7'd20);
      wait_idle();

      // Command only.
      send(8'h06, 32'd0, 32'd0, 3'b000, 7'd0);
      wait_idle();

      // Read clamps 40 bits to 32.
      miso_pat = 64'hFFFF_FFFF_FFFF_FFFF;
      send(8'h0B, 32'hAB12_3456, 32'd0, 3'b010, 7'd40);
      wait_idle();

      // Command + address, reserved type, and a read with zero bits.
      send(8'hD8, 32'h0012_3456, 32'd0, 3'b100, 7'd9);
      wait_idle();
      send(8'hC7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b110, 7'd16);
      wait_idle();
      send(8'h03, 32'h00AB_CDEF, 32'd0, 3'b010, 7'd0);
      wait_idle();

      // Short odd-width read.
      miso_pat = {8'h00, 5'b10110, 51'd0};
      send(8'h9F, 32'd0, 32'd0, 3'b001, 7'd5);
      wait_idle();

      // validflag during an active frame is ignored.
      miso_pat = {8'h00, 8'h3C, 48'd0};
      vf0 = vf_cnt;
      send(8'h9F, 32'd0, 32'd0, 3'b001, 7'd8);
      repeat (5) @(negedge clk);
      command = 8'hAB; commtype = 3'b011; validflag = 1'b1;
      @(negedge clk);
      validflag = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check("vf_count_ignore", 64'(vf_cnt), 64'(vf0 + 1));

      // Reset mid-frame aborts without a done pulse.
      vf0 = vf_cnt;
      send(8'h02, 32'h0011_2233, 32'hDEAD_BEEF, 3'b011, 7'd0);
      repeat (20) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("abort_ss", 64'(ss), 64'd1);
      check("abort_sclk", 64'(sclk), 64'd0);
      check("abort_tready", 64'(tready), 64'd1);
      check("abort_dout", 64'(data_out), 64'd0);
      dropped = exp_q.pop_back();
      model_dout = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("abort_no_vf", 64'(vf_cnt), 64'(vf0));

      // A new request after reset completes normally.
      miso_pat = {8'h00, 12'h5A7, 44'd0};
      send(8'h05, 32'd0, 32'd0, 3'b001, 7'd12);
      wait_idle();
      check("vf_after_reset", 64'(vf_cnt), 64'(vf0 + 1));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
